// File: rtl/serializer_piso_if.sv
// Word-in / bit-out bundle for serializer_piso: producer handshake plus serial stream and framing.
interface serializer_piso_if #(parameter int WIDTH = 8);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             dout;
    logic             dout_valid;
    logic             sof;
    logic             eof;
    logic             busy;

    modport master (output in_data, in_valid,
                    input  in_ready, dout, dout_valid, sof, eof, busy);
    modport slave  (input  in_data, in_valid,
                    output in_ready, dout, dout_valid, sof, eof, busy);
endinterface

// File: rtl/serializer_piso.sv
// Parallel-in/serial-out stage: one WIDTH-bit word per handshake, one bit per clock,
// back-to-back words stream with no idle bit between them.
module serializer_piso #(
    parameter int WIDTH      = 8,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input logic clk,
    input logic rst,
    serializer_piso_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sr;
    logic             last;
    logic             accept;
    logic             head;

    // The last bit's cycle is also the reload window, which is what removes the gap.
    assign last         = (state == SHIFT) && (cnt == LAST);
    assign bus.in_ready = !rst && ((state == IDLE) || last);
    assign accept       = bus.in_valid && bus.in_ready;

    assign head           = MSB_FIRST ? sr[WIDTH-1] : sr[0];
    assign bus.dout       = (state == SHIFT) ? head : IDLE_LEVEL;
    assign bus.dout_valid = (state == SHIFT);
    assign bus.busy       = (state == SHIFT);
    assign bus.sof        = (state == SHIFT) && (cnt == '0);
    assign bus.eof        = last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            sr    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        sr    <= bus.in_data;
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (!last) begin
                        sr  <= MSB_FIRST ? {sr[WIDTH-2:0], 1'b0} : {1'b0, sr[WIDTH-1:1]};
                        cnt <= cnt + 1'b1;
                    end else if (accept) begin
                        sr  <= bus.in_data;
                        cnt <= '0;
                    end else begin
                        cnt   <= '0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serializer_piso.sv
// Three serializer variants (8/MSB, 8/LSB idle-high, 2/MSB) checked every cycle against a
// word/bit-position model, plus literal checks of the captured bit streams.
module tb_serializer_piso;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    serializer_piso_if #(.WIDTH(8)) b0 ();
    serializer_piso_if #(.WIDTH(8)) b1 ();
    serializer_piso_if #(.WIDTH(2)) b2 ();

    serializer_piso #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u0 (.clk(clk), .rst(rst), .bus(b0));
    serializer_piso #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u1 (.clk(clk), .rst(rst), .bus(b1));
    serializer_piso #(.WIDTH(2), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u2 (.clk(clk), .rst(rst), .bus(b2));

    logic [31:0] tdata [3];
    logic [2:0]  tvalid;
    logic [2:0]  rdy, dout, dv, sof, eof, bsy;

    assign b0.in_data = tdata[0][7:0];
    assign b1.in_data = tdata[1][7:0];
    assign b2.in_data = tdata[2][1:0];
    assign b0.in_valid = tvalid[0];
    assign b1.in_valid = tvalid[1];
    assign b2.in_valid = tvalid[2];
    assign rdy  = {b2.in_ready,   b1.in_ready,   b0.in_ready};
    assign dout = {b2.dout,       b1.dout,       b0.dout};
    assign dv   = {b2.dout_valid, b1.dout_valid, b0.dout_valid};
    assign sof  = {b2.sof,        b1.sof,        b0.sof};
    assign eof  = {b2.eof,        b1.eof,        b0.eof};
    assign bsy  = {b2.busy,       b1.busy,       b0.busy};

    function automatic int lw(int i);
        return (i == 2) ? 2 : 8;
    endfunction
    function automatic bit lmsb(int i);
        return (i != 1);
    endfunction
    function automatic bit lidle(int i);
        return (i == 1);
    endfunction

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int lane, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s lane%0d: got %0h expected %0h at %0t", name, lane, got, exp, $time);
        end
    endtask

    // Model: the word being emitted and how many of its bits remain (including the current one).
    logic [31:0] mword [3];
    int          mleft [3];
    initial for (int i = 0; i < 3; i++) begin mword[i] = '0; mleft[i] = 0; end

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            bit acc;
            acc = tvalid[i] && !rst && (mleft[i] <= 1);
            if (rst) mleft[i] = 0;
            else if (mleft[i] > 0) mleft[i] = mleft[i] - 1;
            if (acc) begin
                mword[i] = tdata[i];
                mleft[i] = lw(i);
            end
        end
    end

    // Captured transmitted bits, framing counts and a 101 window count on lane 0's raw stream.
    logic [63:0] cap  [3];
    int          ncap [3];
    int          nsof [3];
    int          neof [3];
    logic [2:0]  hist = 3'b000;
    int          n101 = 0;

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            int  pos;
            bit  ev, ed;
            ev  = (mleft[i] > 0);
            pos = lw(i) - mleft[i];
            ed  = ev ? (lmsb(i) ? mword[i][lw(i)-1-pos] : mword[i][pos]) : lidle(i);
            chk("in_ready",   i, 64'(rdy[i]),  64'(!rst && mleft[i] <= 1));
            chk("dout",       i, 64'(dout[i]), 64'(ed));
            chk("dout_valid", i, 64'(dv[i]),   64'(ev));
            chk("busy",       i, 64'(bsy[i]),  64'(ev));
            chk("sof",        i, 64'(sof[i]),  64'(ev && pos == 0));
            chk("eof",        i, 64'(eof[i]),  64'(mleft[i] == 1));
            if (dv[i]) begin
                cap[i]  = {cap[i][62:0], dout[i]};
                ncap[i] = ncap[i] + 1;
                if (sof[i]) nsof[i] = nsof[i] + 1;
                if (eof[i]) neof[i] = neof[i] + 1;
            end
        end
        hist = {hist[1:0], dout[0]};
        if (hist == 3'b101) n101 = n101 + 1;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clr(input int i);
        cap[i] = '0; ncap[i] = 0; nsof[i] = 0; neof[i] = 0;
    endtask

    // Present a word and return just after the edge that accepts it; in_valid is left high.
    task automatic send(input int i, input logic [31:0] d);
        bit ok;
        ok = 1'b0;
        tvalid[i] = 1'b1;
        tdata[i]  = d;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (rdy[i]) begin ok = 1'b1; break; end
        end
        chk("send_timeout", i, 64'(ok), 64'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin tdata[i] = '0; clr(i); end
        rst = 1'b1;
        tvalid = 3'b001;
        tdata[0] = 32'h55;
        cyc(3);
        rst = 1'b0;
        tvalid = 3'b000;
        cyc(2);
        chk("reset_no_accept", 0, 64'(ncap[0]), 64'd0);

        clr(0); n101 = 0;
        send(0, 32'hA0); tvalid[0] = 1'b0; cyc(10);
        chk("msb_word", 0, cap[0], 64'hA0);
        chk("msb_len",  0, 64'(ncap[0]), 64'd8);
        chk("moore101", 0, 64'(n101), 64'd1);

        clr(1);
        send(1, 32'h05); tvalid[1] = 1'b0; cyc(10);
        chk("lsb_word", 1, cap[1], 64'hA0);
        chk("lsb_len",  1, 64'(ncap[1]), 64'd8);

        clr(0);
        send(0, 32'h81); send(0, 32'h7E); tvalid[0] = 1'b0; cyc(18);
        chk("b2b_stream", 0, cap[0], 64'h817E);
        chk("b2b_len",    0, 64'(ncap[0]), 64'd16);
        chk("b2b_sof",    0, 64'(nsof[0]), 64'd2);

        clr(0);
        send(0, 32'h3C); tvalid[0] = 1'b0; tdata[0] = 32'hFF;
        cyc(2); tdata[0] = 32'hC3;
        send(0, 32'hC3); tvalid[0] = 1'b0; cyc(10);
        chk("bp_stream", 0, cap[0], 64'h3CC3);
        chk("bp_len",    0, 64'(ncap[0]), 64'd16);

        clr(0);
        send(0, 32'hFF); tvalid[0] = 1'b0; cyc(3);
        rst = 1'b1; tvalid[0] = 1'b1; tdata[0] = 32'hAA;
        cyc(1);
        rst = 1'b0; tvalid[0] = 1'b0;
        cyc(6);
        chk("rst_stream", 0, cap[0], 64'hF);
        chk("rst_len",    0, 64'(ncap[0]), 64'd4);

        clr(2);
        for (int k = 0; k < 5; k++) send(2, 32'h2);
        tvalid[2] = 1'b0; cyc(4);
        chk("w2_stream", 2, cap[2], 64'h2AA);
        chk("w2_len",    2, 64'(ncap[2]), 64'd10);
        chk("w2_sof",    2, 64'(nsof[2]), 64'd5);
        chk("w2_eof",    2, 64'(neof[2]), 64'd5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
